// File: rtl/isa_pkg.sv
// Shared ISA decode constants and memory-stage state encoding.
package isa_pkg;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 27;
  localparam int unsigned RD_HI  = 26;
  localparam int unsigned RD_LO  = 22;
  localparam int unsigned OPC_W  = 5;
  localparam int unsigned REG_W  = 5;

  localparam logic [OPC_W-1:0] OP_SW = 5'b00111;
  localparam logic [OPC_W-1:0] OP_LW = 5'b01000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
    return (opc == OP_SW) || (opc == OP_LW);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between mem_stage (master) and the memory (slave).
interface mem_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_req_fsm.sv
// Memory-stage control: IDLE -> ACCESS (hold request until ready) -> DONE, plus stall/mem_req.
module mem_req_fsm
  import isa_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   in_valid,
  input  logic   is_mem,
  input  logic   mem_ready,
  output state_e state,
  output logic   stall,
  output logic   mem_req
);

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && is_mem) begin
          state_d = ACCESS;
          stall   = 1'b1;
        end
      end
      ACCESS: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Reset drops the request and releases the pipeline immediately.
    if (reset) begin
      stall   = 1'b0;
      mem_req = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: lw/sw over a variable-latency memory bus, pass-through for other instructions.
// Optional WM_BYPASS_EN: forward writeback data into the store data at sw capture.
module mem_stage
  import isa_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_IR,
  input  logic [DATA_W-1:0] in_O,
  input  logic [DATA_W-1:0] in_B,
  input  logic              w_we,
  input  logic [REG_W-1:0]  w_rd,
  input  logic [DATA_W-1:0] w_data,
  mem_stage_if.master       mem,
  output logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_IR,
  output logic [DATA_W-1:0] out_O,
  output logic [DATA_W-1:0] out_D
);

  state_e            state;
  logic              is_mem_in;
  logic              is_sw_q;
  logic              req;
  logic [DATA_W-1:0] st_data;
  logic [DATA_W-1:0] ir_q, ir_d, o_q, o_d, b_q, b_d, d_q, d_d;

  assign is_mem_in = is_mem_op(in_IR[OPC_HI:OPC_LO]);
  assign is_sw_q   = (ir_q[OPC_HI:OPC_LO] == OP_SW);

`ifdef WM_BYPASS_EN
  assign st_data = (w_we && (w_rd != '0) && (w_rd == in_IR[RD_HI:RD_LO])) ? w_data : in_B;
`else
  logic unused_w;
  assign st_data  = in_B;
  assign unused_w = ^{w_we, w_rd, w_data};
`endif

  mem_req_fsm u_fsm (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .is_mem    (is_mem_in),
    .mem_ready (mem.mem_ready),
    .state     (state),
    .stall     (stall),
    .mem_req   (req)
  );

  assign mem.mem_req = req;

  // Capture the memory op on entry; latch load data (or zero for a store) on ready.
  always_comb begin
    ir_d = ir_q;
    o_d  = o_q;
    b_d  = b_q;
    d_d  = d_q;
    if (state == IDLE && in_valid && is_mem_in) begin
      ir_d = in_IR;
      o_d  = in_O;
      b_d  = st_data;
    end
    if (state == ACCESS && mem.mem_ready) begin
      d_d = is_sw_q ? '0 : mem.mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q <= '0;
      o_q  <= '0;
      b_q  <= '0;
      d_q  <= '0;
    end else begin
      ir_q <= ir_d;
      o_q  <= o_d;
      b_q  <= b_d;
      d_q  <= d_d;
    end
  end

  always_comb begin
    out_valid     = 1'b0;
    out_IR        = '0;
    out_O         = '0;
    out_D         = '0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (in_valid && !is_mem_in) begin
            out_valid = 1'b1;
            out_IR    = in_IR;
            out_O     = in_O;
          end
        end
        ACCESS: begin
          mem.mem_we    = is_sw_q;
          mem.mem_addr  = o_q[ADDR_W-1:0];
          mem.mem_wdata = b_q;
        end
        DONE: begin
          out_valid = 1'b1;
          out_IR    = ir_q;
          out_O     = o_q;
          out_D     = d_q;
        end
        default: ;
      endcase
    end
  end

endmodule
